// File: rtl/mux_scan.sv
// Registered channel multiplexer: manual capture of one channel or an auto-scan sweep of all channels.
// Optional feature: define MUX_SCAN_MASK_EN to add ch_mask, a per-sweep channel enable mask.
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      req,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      out_ready,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t              state;
  logic [SEL_W-1:0]    counter;
  logic                can_load;

  logic [CHANNELS-1:0] start_mask;
  logic [CHANNELS-1:0] mask_q;

  logic [WIDTH-1:0]    man_data;
  logic [WIDTH-1:0]    scan_data;
  logic                cur_en;
  logic [SEL_W-1:0]    first_ch;
  logic [SEL_W-1:0]    next_ch;
  logic                next_found;

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out and out_ch are held and nothing new loads.
  assign can_load = !out_valid || out_ready;

  // busy is the registered FSM state seen from outside.
  assign busy = (state == SCAN);

`ifdef MUX_SCAN_MASK_EN
  assign start_mask = ch_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (state == IDLE && mode && start) begin
      mask_q <= ch_mask;
    end
  end
`else
  assign start_mask = '1;
  assign mask_q     = '1;
`endif

  // Manual path: out-of-range sel (non power-of-two CHANNELS) yields zero data.
  always_comb begin
    man_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        man_data = in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    scan_data = '0;
    cur_en    = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (counter == SEL_W'(k)) begin
        scan_data = in[k*WIDTH +: WIDTH];
        cur_en    = mask_q[k];
      end
    end
  end

  // Descending walk so the last hit is the lowest qualifying channel.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (start_mask[k]) begin
        first_ch = SEL_W'(k);
      end
      if (mask_q[k] && (SEL_W'(k) > counter)) begin
        next_found = 1'b1;
        next_ch    = SEL_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (can_load) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (mode) begin
            if (start) begin
              state   <= SCAN;
              counter <= first_ch;
            end
          end else if (req && can_load) begin
            out       <= man_data;
            out_ch    <= sel;
            out_valid <= 1'b1;
          end
        end
        SCAN: begin
          // counter only rests on a disabled channel when the sampled mask was empty.
          if (!cur_en) begin
            state   <= IDLE;
            counter <= '0;
            done    <= 1'b1;
          end else if (can_load) begin
            out       <= scan_data;
            out_ch    <= counter;
            out_valid <= 1'b1;
            if (next_found) begin
              counter <= next_ch;
            end else begin
              state   <= IDLE;
              counter <= '0;
              done    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a manual-capture vector table, hand-written multi-cycle sequences, and
// randomized sweeps scored against a list-of-enabled-channels model (MUX_SCAN_MASK_EN optional).
module tb_mux_scan;

  typedef struct {
    int         which;   // 0: WIDTH=1 instance, 1: main instance, 2: CHANNELS=10 instance
    logic [3:0] sel;
    logic [7:0] exp_out;
  } vec_t;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: WIDTH=8, CHANNELS=16
  logic [127:0] m_in;
  logic [3:0]   m_sel;
  logic         m_req, m_mode, m_start, m_ready;
  logic [7:0]   m_out;
  logic [3:0]   m_ch;
  logic         m_valid, m_busy, m_done;
`ifdef MUX_SCAN_MASK_EN
  logic [15:0]  m_mask;
`endif

  // WIDTH=1 instance
  logic [15:0]  w_in;
  logic [3:0]   w_sel;
  logic         w_req;
  logic [0:0]   w_out;
  logic [3:0]   w_ch;
  logic         w_valid, w_busy, w_done;

  // CHANNELS=10 instance
  logic [79:0]  c_in;
  logic [3:0]   c_sel;
  logic         c_req;
  logic [7:0]   c_out;
  logic [3:0]   c_ch;
  logic         c_valid, c_busy, c_done;

  mux_scan #(.WIDTH(8), .CHANNELS(16)) u_main (
    .clk(clk), .rst_n(rst_n), .in(m_in), .sel(m_sel), .req(m_req), .mode(m_mode),
    .start(m_start), .out_ready(m_ready),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(m_mask),
`endif
    .out(m_out), .out_ch(m_ch), .out_valid(m_valid), .busy(m_busy), .done(m_done)
  );

  mux_scan #(.WIDTH(1), .CHANNELS(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in(w_in), .sel(w_sel), .req(w_req), .mode(1'b0),
    .start(1'b0), .out_ready(1'b1),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(16'hffff),
`endif
    .out(w_out), .out_ch(w_ch), .out_valid(w_valid), .busy(w_busy), .done(w_done)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(10)) u_c10 (
    .clk(clk), .rst_n(rst_n), .in(c_in), .sel(c_sel), .req(c_req), .mode(1'b0),
    .start(1'b0), .out_ready(1'b1),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(10'h3ff),
`endif
    .out(c_out), .out_ch(c_ch), .out_valid(c_valid), .busy(c_busy), .done(c_done)
  );

  int         n_vec;
  int         n_err;
  logic [11:0] exp_q[$];        // {channel, data} beats still owed by the current sweep
  logic [7:0] chan_val[16];     // reference copy of the main instance channel data
  vec_t       vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got beat %0h, expected no beat", name, act);
  endtask

  task automatic pack_in();
    for (int k = 0; k < 16; k++) m_in[k*8 +: 8] = chan_val[k];
  endtask

  task automatic drain();
    m_mode  = 1'b0;
    m_req   = 1'b0;
    m_start = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4 && m_valid; i++) step();
  endtask

  task automatic apply_manual(input int which, input logic [3:0] s, input logic [7:0] exp_o,
                              input string tag);
    case (which)
      0: begin w_sel = s; w_req = 1'b1; end
      1: begin m_mode = 1'b0; m_start = 1'b0; m_ready = 1'b1; m_sel = s; m_req = 1'b1; end
      default: begin c_sel = s; c_req = 1'b1; end
    endcase
    step();
    w_req = 1'b0;
    m_req = 1'b0;
    c_req = 1'b0;
    case (which)
      0: begin
        check({tag, "_out"}, w_out, exp_o);
        check({tag, "_ch"}, w_ch, s);
        check({tag, "_valid"}, w_valid, 1);
      end
      1: begin
        check({tag, "_out"}, m_out, exp_o);
        check({tag, "_ch"}, m_ch, s);
        check({tag, "_valid"}, m_valid, 1);
      end
      default: begin
        check({tag, "_out"}, c_out, exp_o);
        check({tag, "_ch"}, c_ch, s);
        check({tag, "_valid"}, c_valid, 1);
      end
    endcase
  endtask

  // rmode 0: out_ready always 1; rmode 1: random out_ready. stall_ch >= 0 holds out_ready low
  // for three cycles the first time that channel is presented.
  task automatic sweep(input int rmode, input int stall_ch, input logic [15:0] mask,
                       input string tag);
    logic [15:0] en;
    logic [11:0] e;
    int          cyc;
    int          done_cnt;
    int          done_at;
    int          stalls;
    int          n_exp;
    drain();
`ifdef MUX_SCAN_MASK_EN
    m_mask = mask;
    en     = mask;
`else
    en     = 16'hffff;
`endif
    exp_q.delete();
    for (int ch = 0; ch < 16; ch++) begin
      if (en[ch]) exp_q.push_back({4'(ch), chan_val[ch]});
    end
    n_exp   = exp_q.size();
    m_mode  = 1'b1;
    m_start = 1'b1;
    m_req   = 1'($urandom_range(0, 1));
    m_sel   = 4'($urandom_range(0, 15));
    step();
    m_start  = 1'b0;
    m_req    = 1'b0;
    cyc      = 1;
    done_cnt = 0;
    done_at  = 0;
    stalls   = 3;
    while (cyc < 400 && !(done_cnt > 0 && !m_valid)) begin
      if (cyc == 1) check({tag, "_busy"}, m_busy, 1);
      if (m_busy) begin
        m_start = 1'($urandom_range(0, 1));
        m_req   = 1'($urandom_range(0, 1));
        m_mode  = 1'($urandom_range(0, 1));
        m_sel   = 4'($urandom_range(0, 15));
`ifdef MUX_SCAN_MASK_EN
        m_mask  = 16'($urandom);
`endif
      end else begin
        m_start = 1'b0;
        m_req   = 1'b0;
        m_mode  = 1'b0;
      end
      if (m_done) begin
        done_cnt++;
        done_at = cyc;
        check({tag, "_done_busy"}, m_busy, 0);
        check({tag, "_done_left"}, exp_q.size(), (n_exp > 0) ? 1 : 0);
      end
      m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (stall_ch >= 0 && m_valid && m_ch == stall_ch && stalls > 0) begin
        m_ready = 1'b0;
        stalls--;
        check({tag, "_stall_hold"}, {m_ch, m_out}, {4'(stall_ch), chan_val[stall_ch]});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          flag({tag, "_extra_beat"}, {m_ch, m_out});
        end else begin
          e = exp_q.pop_front();
          check({tag, "_beat"}, {m_ch, m_out}, e);
        end
      end
      step();
      cyc++;
    end
    m_ready = 1'b1;
    m_mode  = 1'b0;
    m_req   = 1'b0;
    m_start = 1'b0;
    check({tag, "_in_time"}, cyc < 400, 1);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_done_low"}, m_done, 0);
    check({tag, "_idle"}, m_busy, 0);
    if (rmode == 0 && stall_ch < 0) begin
      check({tag, "_done_cycle"}, done_at, ((n_exp > 0) ? n_exp : 1) + 1);
    end
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  s;
    logic [15:0] rmask;
    logic        found;
    logic        saw_done;
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    m_in    = '0;
    m_sel   = '0;
    m_req   = 1'b0;
    m_mode  = 1'b0;
    m_start = 1'b0;
    m_ready = 1'b1;
`ifdef MUX_SCAN_MASK_EN
    m_mask  = 16'hffff;
`endif
    w_in  = 16'h3f0a;
    w_sel = '0;
    w_req = 1'b0;
    c_sel = '0;
    c_req = 1'b0;
    for (int k = 0; k < 10; k++) c_in[k*8 +: 8] = 8'ha0 + 8'(k);
    for (int k = 0; k < 16; k++) chan_val[k] = 8'h10 + 8'(k);
    pack_in();

    vecs[0]  = '{0, 4'h0, 8'h00};
    vecs[1]  = '{0, 4'h1, 8'h01};
    vecs[2]  = '{0, 4'h6, 8'h00};
    vecs[3]  = '{0, 4'hc, 8'h01};
    vecs[4]  = '{0, 4'h3, 8'h01};
    vecs[5]  = '{0, 4'h8, 8'h01};
    vecs[6]  = '{0, 4'hf, 8'h00};
    vecs[7]  = '{0, 4'h4, 8'h00};
    vecs[8]  = '{1, 4'h0, 8'h10};
    vecs[9]  = '{1, 4'h7, 8'h17};
    vecs[10] = '{1, 4'hf, 8'h1f};
    vecs[11] = '{2, 4'hc, 8'h00};
    vecs[12] = '{2, 4'h9, 8'ha9};
    vecs[13] = '{2, 4'h0, 8'ha0};
    vecs[14] = '{2, 4'hf, 8'h00};
    vecs[15] = '{2, 4'ha, 8'h00};

    repeat (2) step();
    check("rst_out", m_out, 0);
    check("rst_ch", m_ch, 0);
    check("rst_valid", m_valid, 0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_w1_valid", w_valid, 0);
    check("rst_c10_valid", c_valid, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      apply_manual(vecs[i].which, vecs[i].sel, vecs[i].exp_out, $sformatf("vec%0d", i));
    end

    // start with mode=0 is ignored
    drain();
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    check("start_mode0_busy", m_busy, 0);
    check("start_mode0_valid", m_valid, 0);

    // start and req together with mode=0: manual capture wins
    m_start = 1'b1;
    m_req   = 1'b1;
    m_sel   = 4'd3;
    step();
    m_start = 1'b0;
    m_req   = 1'b0;
    check("start_req_busy", m_busy, 0);
    check("start_req_ch", m_ch, 3);
    check("start_req_out", m_out, 8'h13);

    // manual beat held under backpressure; a pending req waits for the stage
    drain();
    m_ready = 1'b0;
    m_sel   = 4'd2;
    m_req   = 1'b1;
    step();
    check("hold_first_out", m_out, 8'h12);
    m_sel = 4'd7;
    step();
    check("hold_kept_out", m_out, 8'h12);
    check("hold_kept_ch", m_ch, 2);
    check("hold_kept_valid", m_valid, 1);
    m_ready = 1'b1;
    step();
    check("hold_next_ch", m_ch, 7);
    check("hold_next_out", m_out, 8'h17);
    m_req = 1'b0;
    step();
    check("hold_drained_valid", m_valid, 0);

    sweep(0, -1, 16'hffff, "full");
    sweep(0, 5, 16'hffff, "bp");
`ifdef MUX_SCAN_MASK_EN
    sweep(0, -1, 16'h8421, "mask");
    sweep(0, -1, 16'h0000, "mask0");
`endif

    // reset while channel 9 is presented
    drain();
`ifdef MUX_SCAN_MASK_EN
    m_mask = 16'hffff;
`endif
    m_mode  = 1'b1;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    m_mode  = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_valid && m_ch == 4'd9) found = 1'b1;
      else step();
    end
    check("rst_mid_reach_ch9", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out", m_out, 0);
    check("rst_mid_ch", m_ch, 0);
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_busy", m_busy, 0);
    check("rst_mid_done", m_done, 0);
    saw_done = 1'b0;
    repeat (2) begin
      step();
      if (m_done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      if (m_done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", saw_done, 0);
    check("rst_mid_idle", m_busy, 0);
    sweep(0, -1, 16'hffff, "post_rst");

    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 16; k++) chan_val[k] = 8'($urandom_range(0, 255));
      pack_in();
      rmask = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          for (int j = 0; j < 4; j++) begin
            s = 4'($urandom_range(0, 15));
            apply_manual(1, s, chan_val[s], "rand_man");
          end
        end
        1: sweep(1, -1, rmask, "rand_bp");
        default: sweep(0, -1, rmask, "rand_full");
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 8, bits per channel.
REQ-002 Parameter CHANNELS, default 16, number of input channels; legal range 2..256.
REQ-003 Parameter SEL_W, default $clog2(CHANNELS), width of select and channel-index fields.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel index for manual capture.
REQ-008 req  input  1  manual capture request (mode=0).
REQ-009 mode  input  1  0 = manual, 1 = auto-scan.
REQ-010 start  input  1  single-cycle pulse that starts an auto-scan sweep.
REQ-011 out_ready  input  1  downstream accepts the current beat.
REQ-012 out  output  WIDTH  registered selected data.
REQ-013 out_ch  output  SEL_W  channel index of the current beat.
REQ-014 out_valid  output  1  out and out_ch hold a beat.
REQ-015 busy  output  1  high while in SCAN.
REQ-016 done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-017 Output stage can load when (!out_valid || out_ready); a held beat keeps out and out_ch stable until accepted.
REQ-018 FSM states: IDLE and SCAN; busy = (state == SCAN).
REQ-019 IDLE, mode=0, req=1, stage can load: capture in[sel], out_ch=sel, out_valid=1 at the next edge; latency 1 cycle.
REQ-020 sel >= CHANNELS (non-power-of-2 CHANNELS): out=0, out_ch=sel, out_valid=1.
REQ-021 IDLE, mode=1, start=1: go to SCAN with scan counter = first enabled channel (channel 0 when masking is disabled).
REQ-022 SCAN: on each edge where the stage can load, present in[counter] and out_ch=counter with out_valid=1, then advance counter to the next enabled channel.
REQ-023 Backpressure (out_valid && !out_ready) freezes the counter; channels are never skipped or duplicated.
REQ-024 After the last channel's beat is loaded, return to IDLE on the same edge; done pulses in the cycle after that edge; no counter wrap.
REQ-025 Empty stage with no new load: out_valid falls to 0 when the held beat is accepted.
REQ-026 start during SCAN, req during SCAN and start with mode=0 are ignored; mode is sampled only at start.
REQ-027 start and req asserted in the same IDLE cycle: mode selects the action.

Reset
REQ-028 rst_n low, asynchronously: state=IDLE, counter=0, out=0, out_ch=0, out_valid=0, busy=0, done=0.
REQ-029 Reset mid-sweep abandons the sweep with no done pulse; operation resumes on the first edge after rst_n rises.

Configuration
REQ-030 Macro MUX_SCAN_MASK_EN defined: add input ch_mask (CHANNELS bits), sampled at start; a sweep visits only channels with a mask bit of 1, in ascending order.
REQ-031 MUX_SCAN_MASK_EN defined, all mask bits 0: the sweep emits no beats and done pulses two cycles after start.
REQ-032 MUX_SCAN_MASK_EN undefined: no ch_mask port; every sweep visits all CHANNELS channels.

Verification
REQ-033 Manual capture: WIDTH=1, CHANNELS=16, in=16'h3f0a, out_ready=1, sel=0,1,6,c with req pulses -> out=0,1,0,1 each one cycle after its request, out_ch matching sel.
REQ-034 Full sweep: WIDTH=8, in[k]=k+8'h10, out_ready=1, one start pulse -> 16 consecutive beats 8'h10..8'h1f with out_ch 0..15, then one done pulse, busy low after the sweep.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles at channel 5 -> out=8'h15 stable for 3 cycles, next beat is channel 6, exactly 16 beats total.
REQ-036 Reset mid-sweep: assert rst_n low at channel 9 -> all outputs 0 immediately, no done pulse; a new start gives a full sweep from channel 0.
REQ-037 With MUX_SCAN_MASK_EN, ch_mask=16'h8421 -> beats on channels 0,5,10,15 only, then done; ch_mask=0 -> no beats, done two cycles after start.
REQ-038 CHANNELS=10, manual sel=12 -> out=0, out_ch=12, out_valid=1.
